fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch path: owns the program counter, issues one-at-a-time requests to instruction memory over a valid/ready handshake, and holds each returned word for the decode stage. It also applies control-flow redirects from execute and discards in-flight responses that a redirect makes stale. It sits between instruction memory and decode, in place of a free-running PC increment.

---
 rtl/riscv_pkg.sv | 7 +
 rtl/fetch_ctrl.sv | 90 +++++++++
 tb/tb_fetch_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, fetch FSM states and constants for the fetch path.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner issuing one outstanding imem request at a time, holding the
// returned word for decode and draining responses made stale by redirects.
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, issued_pc_q, issued_pc_d, instr_pc_q, instr_pc_d, redir_pc;
   logic [ILEN-1:0] instr_q, instr_d;

   assign redir_pc       = {redirect_pc[XLEN-1:2], 2'b00};
   assign imem_req_valid = state_q == REQ;
   assign imem_req_addr  = pc_q;
   assign instr_valid    = state_q == HOLD && !redirect_valid;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issued_pc_d = issued_pc_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_req_ready) begin
               issued_pc_d = pc_q;
               state_d     = redirect_valid ? DRAIN : WAIT;
            end
            if (redirect_valid) pc_d = redir_pc;
         end
         WAIT: begin
            if (imem_rsp_valid && !redirect_valid) begin
               state_d    = HOLD;
               instr_d    = imem_rsp_data;
               instr_pc_d = issued_pc_q;
               pc_d       = issued_pc_q + 32'd4;
            end else if (redirect_valid) begin
               state_d = imem_rsp_valid ? REQ : DRAIN;
               pc_d    = redir_pc;
            end
         end
         DRAIN: begin
            if (redirect_valid) pc_d = redir_pc;
            if (imem_rsp_valid) state_d = REQ;
         end
         HOLD: begin
            if (redirect_valid) pc_d = redir_pc;
            if (redirect_valid || instr_ready) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         issued_pc_q <= RESET_PC;
         instr_q     <= '0;
         instr_pc_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issued_pc_q <= issued_pc_d;
         instr_q     <= instr_d;
         instr_pc_q  <= instr_pc_d;
      end
   end

   // A response with nothing outstanding breaks the one-request protocol.
   rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (state_q == WAIT || state_q == DRAIN));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed fetch traffic against a transaction-level
// model of the fetch stream (expected next PC, one outstanding fetch, stale drops).
module tb_fetch_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0;
   logic        instr_valid, instr_ready = 0;
   logic [31:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0, instr, instr_pc;
   logic        b_req_valid, b_req_ready = 0, b_rsp_valid = 0, b_instr_valid, b_instr_ready = 0;
   logic [31:0] b_req_addr, b_rsp_data = 0, b_instr, b_instr_pc;

   fetch_ctrl u_dut (
      .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc));

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .clk(clk), .rst(rst), .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready),
      .imem_req_addr(b_req_addr), .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .instr_valid(b_instr_valid),
      .instr_ready(b_instr_ready), .instr(b_instr), .instr_pc(b_instr_pc));

   int total = 0, bad = 0, cyc = 0, rsp_c = -1, iv_c = -1;
   int rdy_mode = 1, ir_mode = 1, lat_max = 1, vld_cnt = 0;
   logic rnd_redir = 0, rd_v = 0, prev_iv = 0;
   logic [31:0] rd_pc = 0, exp_pc = 0;
   logic cur_v = 0, cur_stale = 0, cur_resp = 0, m_pend = 0, b_pend = 0;
   logic [31:0] cur_addr = 0, m_addr = 0, b_addr = 0;
   int m_cnt = 0;
   logic [31:0] acc_q[$], del_q[$], b_acc[$], b_del[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h1234};
   endfunction

   task automatic sample();
      logic hs, acc;
      hs  = instr_valid && instr_ready;
      acc = imem_req_valid && imem_req_ready;
      if (redirect_valid) chk("redirect_kills_valid", 32'(instr_valid), 0);
      if (instr_valid) begin
         chk("valid_needs_live_fetch", {29'b0, cur_v, cur_resp, cur_stale}, 32'b110);
         chk("instr_pc", instr_pc, cur_addr);
         chk("instr_word", instr, mem_word(cur_addr));
         vld_cnt++;
      end
      if (instr_valid && !prev_iv) iv_c = cyc;
      prev_iv = instr_valid;
      if (imem_req_valid) begin
         chk("one_outstanding", 32'(cur_v), 0);
         chk("req_addr", imem_req_addr, exp_pc);
      end
      if (imem_rsp_valid) rsp_c = cyc;
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      else if (hs) exp_pc = cur_addr + 32'd4;
      if (acc) begin
         cur_v = 1; cur_addr = imem_req_addr; cur_stale = redirect_valid; cur_resp = 0;
         acc_q.push_back(imem_req_addr);
         m_pend = 1; m_addr = imem_req_addr; m_cnt = int'($urandom_range(1, lat_max));
      end else if (cur_v) begin
         if (imem_rsp_valid) begin cur_resp = 1; m_pend = 0; end
         if (redirect_valid) cur_stale = 1;
         if (hs) begin del_q.push_back(cur_addr); cur_v = 0; end
         else if (cur_resp && cur_stale) cur_v = 0;
      end
      if (b_rsp_valid) b_pend = 0;
      if (b_req_valid && b_req_ready) begin b_pend = 1; b_addr = b_req_addr; b_acc.push_back(b_req_addr); end
      if (b_instr_valid) b_del.push_back(b_instr_pc);
   endtask

   task automatic tick();
      @(posedge clk); #1;
      imem_req_ready = rdy_mode == 2 ? 1'b0 : rdy_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      imem_rsp_valid = m_pend && m_cnt == 1;
      imem_rsp_data  = imem_rsp_valid ? mem_word(m_addr) : $urandom;
      if (m_pend && m_cnt > 1) m_cnt--;
      instr_ready    = ir_mode == 2 ? 1'b0 : ir_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      redirect_valid = rd_v || (rnd_redir && $urandom_range(0, 9) == 0);
      redirect_pc    = rd_v ? rd_pc : $urandom;
      b_req_ready = 1; b_instr_ready = 1;
      b_rsp_valid = b_pend;
      b_rsp_data  = mem_word(b_addr);
      @(negedge clk);
      sample();
      cyc++;
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst2_req_valid", 32'(b_req_valid), 0);
      chk("rst2_req_addr", b_req_addr, 32'hFFFF_FFFC);
      chk("rst2_instr_valid", 32'(b_instr_valid), 0);
      chk("rst2_instr", b_instr, 0);
      chk("rst2_instr_pc", b_instr_pc, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0; instr_ready = 0;
      b_req_ready = 0; b_rsp_valid = 0; b_instr_ready = 0;
      m_pend = 0; b_pend = 0; cur_v = 0; exp_pc = 0; prev_iv = 0; rd_v = 0;
      acc_q.delete(); del_q.delete(); b_acc.delete(); b_del.delete();
      repeat (2) @(posedge clk);
      #1 chk_reset_vals();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic wait_acc(input int n);
      for (int i = 0; i < 60 && acc_q.size() < n; i++) tick();
      chk("accept_count", 32'(acc_q.size()), 32'(n));
   endtask

   initial begin
      int v0, hit;
      do_reset();
      v0 = vld_cnt;
      repeat (9) tick();
      chk("zw_valid_1_in_3", 32'(vld_cnt - v0), 3);
      for (int i = 0; i < 3; i++) begin
         chk("zw_req_addr", acc_q.size() > i ? acc_q[i] : 32'hDEAD, 32'(4 * i));
         chk("zw_instr_pc", del_q.size() > i ? del_q[i] : 32'hDEAD, 32'(4 * i));
      end
      chk("wrap_req0", b_acc.size() > 0 ? b_acc[0] : 32'hDEAD, 32'hFFFF_FFFC);
      chk("wrap_req1", b_acc.size() > 1 ? b_acc[1] : 32'hDEAD, 32'h0);
      chk("wrap_instr_pc", b_del.size() > 0 ? b_del[0] : 32'hDEAD, 32'hFFFF_FFFC);

      do_reset();
      for (int i = 0; i < 20 && !b_rsp_valid; i++) tick();
      chk("reach_wait2", 32'(b_rsp_valid), 1);
      #1 rst = 1;
      #1 chk_reset_vals();
      do_reset();

      rdy_mode = 2;
      repeat (4) begin
         tick();
         chk("stall_addr", imem_req_addr, 0);
      end
      rdy_mode = 1;
      repeat (3) tick();
      chk("stall_one_accept", 32'(acc_q.size()), 1);
      chk("stall_delivered", 32'(del_q.size()), 1);
      chk("valid_after_rsp", 32'(iv_c), 32'(rsp_c + 1));

      do_reset();
      wait_acc(5);
      chk("fetched_10", acc_q.size() > 4 ? acc_q[4] : 32'hDEAD, 32'h10);
      rd_v = 1; rd_pc = 32'h200;
      tick();
      rd_v = 0;
      wait_acc(6);
      chk("redir_wait_addr", acc_q.size() > 5 ? acc_q[5] : 32'hDEAD, 32'h200);
      repeat (4) tick();
      hit = 0;
      foreach (del_q[i]) if (del_q[i] == 32'h10) hit++;
      chk("stale_10_dropped", 32'(hit), 0);

      do_reset();
      wait_acc(3);
      tick();
      rd_v = 1; rd_pc = 32'h101;
      tick();
      rd_v = 0;
      chk("hold_kill_valid", 32'(instr_valid), 0);
      chk("hold_kill_pc", instr_pc, 32'h8);
      wait_acc(4);
      chk("redir_hold_addr", acc_q.size() > 3 ? acc_q[3] : 32'hDEAD, 32'h100);
      chk("hold_kill_no_hs", 32'(del_q.size()), 2);

      do_reset();
      ir_mode = 2;
      wait_acc(1);
      repeat (2) tick();
      repeat (5) begin
         tick();
         chk("bp_valid", 32'(instr_valid), 1);
         chk("bp_pc", instr_pc, 0);
         chk("bp_instr", instr, mem_word(0));
         chk("bp_no_req", 32'(imem_req_valid), 0);
      end
      ir_mode = 1;
      tick();
      chk("bp_release", 32'(del_q.size()), 1);

      do_reset();
      rdy_mode = 0; ir_mode = 0; lat_max = 3; rnd_redir = 1;
      repeat (1500) tick();
      chk("random_progress", 32'(del_q.size() > 40), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
